// File: rtl/csi2tx_fifo_pkg.sv
// Shared types, constants and helpers for the CSI-2 transmitter sensor FIFO.
// The FIFO storage is built from 32-bit dual-port RAM slices.
package csi2tx_fifo_pkg;

  localparam int SLICE_WIDTH = 32;

  // Number of address bits needed to index `value` entries (0 for 0 or 1).
  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int          bits;
    v    = (value > 0) ? value - 1 : 0;
    bits = 0;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return bits;
  endfunction

  function automatic bit params_ok(input int data_width, input int addr_width,
                                   input int aempty_thresh, input int afull_thresh,
                                   input int out_reg);
    int depth;
    depth = 1 << addr_width;
    return (data_width > 0) && (data_width % SLICE_WIDTH == 0) &&
           (addr_width >= 2) && (aempty_thresh < afull_thresh) &&
           (afull_thresh <= depth) && (out_reg == 0 || out_reg == 1);
  endfunction

  // Registered occupancy flags, updated together from the next-state pointers.
  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } fifo_flags_t;

endpackage

// File: rtl/csi2tx_dpram_slice.sv
// One 32-bit x DEPTH dual-port RAM slice: write port A, registered read port B,
// both on the same clock.
module csi2tx_dpram_slice
  import csi2tx_fifo_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_we,
  input  logic [AW-1:0]          a_addr,
  input  logic [SLICE_WIDTH-1:0] a_data,
  input  logic                   b_re,
  input  logic [AW-1:0]          b_addr,
  output logic [SLICE_WIDTH-1:0] b_data
);

  logic [SLICE_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; stale words are
  // unreachable because the pointers restart at zero.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_data;
  end

  always_ff @(posedge clk) begin
    if (rst)       b_data <= '0;
    else if (b_re) b_data <= mem[b_addr];
  end

endmodule

// File: rtl/csi2tx_sensor_fifo_ram.sv
// Single-clock sensor-data FIFO between the sensor interface and the CSI-2
// packet builder: sliced RAM storage, registered status, sticky error flags.
module csi2tx_sensor_fifo_ram
  import csi2tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4,
  parameter int OUT_REG       = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  FULL,
  output logic                  AFULL,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  EMPTY,
  output logic                  AEMPTY,
  output logic [ADDR_WIDTH:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  input  logic                  CLR_ERR
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  if (!params_ok(DATA_WIDTH, ADDR_WIDTH, AEMPTY_THRESH, AFULL_THRESH, OUT_REG)) begin : g_param_error
    $error("csi2tx_sensor_fifo_ram: unsupported parameter combination");
  end

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic                  wr_accept, rd_accept;
  logic                  ram_valid;
  logic [DATA_WIDTH-1:0] ram_q;
  fifo_flags_t           flags_nxt;

  // NOTE: combinational logic uses blocking assignments, each output given a
  // value on every path so no latch is inferred.
  always_comb begin
    wr_accept  = WR_EN && !FULL;
    rd_accept  = RD_EN && !EMPTY;
    wr_ptr_nxt = wr_ptr + (ADDR_WIDTH + 1)'(wr_accept);
    rd_ptr_nxt = rd_ptr + (ADDR_WIDTH + 1)'(rd_accept);
    // The wrap bit makes the modular difference the exact fill level.
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    flags_nxt.full   = (level_nxt == DEPTH_L);
    flags_nxt.afull  = (level_nxt >= AFULL_L);
    flags_nxt.empty  = (level_nxt == '0);
    flags_nxt.aempty = (level_nxt <= AEMPTY_L);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      LEVEL     <= '0;
      FULL      <= 1'b0;
      AFULL     <= 1'b0;
      EMPTY     <= 1'b1;
      AEMPTY    <= 1'b1;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
      ram_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      LEVEL     <= level_nxt;
      FULL      <= flags_nxt.full;
      AFULL     <= flags_nxt.afull;
      EMPTY     <= flags_nxt.empty;
      AEMPTY    <= flags_nxt.aempty;
      ram_valid <= rd_accept;
      // A new error in the same cycle as CLR_ERR stays visible.
      if (WR_EN && FULL) OVERFLOW <= 1'b1;
      else if (CLR_ERR)  OVERFLOW <= 1'b0;
      if (RD_EN && EMPTY) UNDERFLOW <= 1'b1;
      else if (CLR_ERR)   UNDERFLOW <= 1'b0;
    end
  end

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    csi2tx_dpram_slice #(
      .DEPTH (DEPTH)
    ) u_slice (
      .clk    (CLK),
      .rst    (RST),
      .a_we   (wr_accept),
      .a_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .a_data (WR_DATA[SLICE_WIDTH*i +: SLICE_WIDTH]),
      .b_re   (rd_accept),
      .b_addr (rd_ptr[ADDR_WIDTH-1:0]),
      .b_data (ram_q[SLICE_WIDTH*i +: SLICE_WIDTH])
    );
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge CLK) begin
      if (RST) begin
        RD_VALID <= 1'b0;
        RD_DATA  <= '0;
      end else begin
        RD_VALID <= ram_valid;
        if (ram_valid) RD_DATA <= ram_q;
      end
    end
  end else begin : g_no_out_reg
    assign RD_VALID = ram_valid;
    assign RD_DATA  = ram_q;
  end

endmodule
